md_scheduler: RTL and testbench

- Multiply/divide controller for the 5-stage MIPS pipeline.
- Sequences a multi-cycle MULT/DIV operation started from EX and owns the HI/LO registers.
- Raises a stall to the hazard unit when the instruction in ID needs the MD unit while it is busy.
- Sits beside the ALU in EX; its Stall output is ORed with the Tuse/Tnew stall logic.

---
 rtl/md_scheduler.sv | 126 ++++++++++++
 tb/tb_md_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the 5-stage MIPS pipeline: owns HI/LO and stalls ID while busy.
// Optional MDU_EARLY_OUT_EN: zero-operand mult and zero-divisor div finish after a single busy cycle.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IdInst,
    input  logic        ExValid,
    input  logic [2:0]  ExOp,
    input  logic [31:0] ExA,
    input  logic [31:0] ExB,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Stall
);
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;

    logic [3:0]  cnt, start_cnt;
    logic [31:0] hi, lo, pend_hi, pend_lo;
    logic        pend_wr;
    logic        is_mult, is_div, start, commit, div_zero, id_is_md;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, uq, ur, quo, rem;
    logic        id_unused;

    assign is_mult  = (ExOp == 3'd1) || (ExOp == 3'd2);
    assign is_div   = (ExOp == 3'd3) || (ExOp == 3'd4);
    assign start    = ExValid && (is_mult || is_div) && (state == IDLE);
    assign div_zero = (ExB == '0);
    assign id_unused = ^IdInst[25:6];

    // One 64x64 multiplier serves both signednesses; the low 64 bits are identical either way.
    always_comb begin
        a_ext = (ExOp == 3'd1) ? {{32{ExA[31]}}, ExA} : {32'b0, ExA};
        b_ext = (ExOp == 3'd1) ? {{32{ExB[31]}}, ExB} : {32'b0, ExB};
        prod  = a_ext * b_ext;
    end

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly with no overflow case.
    always_comb begin
        a_neg = (ExOp == 3'd3) && ExA[31];
        b_neg = (ExOp == 3'd3) && ExB[31];
        a_mag = a_neg ? (32'd0 - ExA) : ExA;
        b_mag = b_neg ? (32'd0 - ExB) : ExB;
        b_div = div_zero ? 32'd1 : b_mag;
        uq    = a_mag / b_div;
        ur    = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem   = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
`ifdef MDU_EARLY_OUT_EN
        if (is_mult)
            start_cnt = ((ExA == '0) || (ExB == '0)) ? 4'd1 : MULT_CNT;
        else
            start_cnt = div_zero ? 4'd1 : DIV_CNT;
`else
        start_cnt = is_mult ? MULT_CNT : DIV_CNT;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state == BUSY);
        commit   = (state == BUSY) && (cnt == 4'd1);
        id_is_md = (IdInst[31:26] == 6'b000000) &&
                   ((IdInst[5:0] == 6'b011000) || (IdInst[5:0] == 6'b011001) ||
                    (IdInst[5:0] == 6'b011010) || (IdInst[5:0] == 6'b011011) ||
                    (IdInst[5:0] == 6'b010000) || (IdInst[5:0] == 6'b010001) ||
                    (IdInst[5:0] == 6'b010010) || (IdInst[5:0] == 6'b010011));
        Stall    = id_is_md && (Busy || (ExValid && (is_mult || is_div)));
        HiOut    = hi;
        LoOut    = lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (start) begin
                cnt     <= start_cnt;
                pend_hi <= is_mult ? prod[63:32] : rem;
                pend_lo <= is_mult ? prod[31:0]  : quo;
                pend_wr <= is_mult || !div_zero;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if ((state == IDLE) && ExValid) begin
                if (ExOp == 3'd5) hi <= ExA;
                if (ExOp == 3'd6) lo <= ExA;
            end
        end
    end
endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: randomized MD traffic against an arithmetic reference model.
// Honours MDU_EARLY_OUT_EN the same way the design does when computing busy lengths.
module tb_md_scheduler;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;
    localparam logic [31:0] I_MFHI = 32'h0000_0010;
    localparam logic [31:0] I_MFLO = 32'h0000_0012;
    localparam logic [31:0] I_ADDU = 32'h0043_0821;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IdInst, ExA, ExB, HiOut, LoOut;
    logic        ExValid, Busy, Stall;
    logic [2:0]  ExOp;

    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .IdInst(IdInst), .ExValid(ExValid), .ExOp(ExOp),
        .ExA(ExA), .ExB(ExB), .HiOut(HiOut), .LoOut(LoOut), .Busy(Busy), .Stall(Stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int busy_from = 1, busy_to = 0;
    bit chk_en = 1'b0;
    bit mon_busy, mon_stall;
    int checks = 0, failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    function automatic bit is_md(input logic [31:0] i);
        logic [5:0] f;
        f = i[5:0];
        return (i[31:26] == 6'd0) &&
               (f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                          6'b010000, 6'b010001, 6'b010010, 6'b010011});
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] md_f [8];
        md_f = '{6'b011000, 6'b011001, 6'b011010, 6'b011011,
                 6'b010000, 6'b010001, 6'b010010, 6'b010011};
        case ($urandom_range(3))
            0, 1:    return {6'd0, 20'($urandom), md_f[$urandom_range(7)]};
            2:       return {6'd0, 20'($urandom), 6'b100001};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    function automatic int unsigned op_cycles(input logic [2:0] op, input logic [31:0] a, b);
        if (op == 3'd1 || op == 3'd2) begin
`ifdef MDU_EARLY_OUT_EN
            if (a == 0 || b == 0) return 1;
`endif
            return MULT_N;
        end
        if (op == 3'd3 || op == 3'd4) begin
`ifdef MDU_EARLY_OUT_EN
            if (b == 0) return 1;
`endif
            return DIV_N;
        end
        return 0;
    endfunction

    // Returns the {HI, LO} that should exist once the operation has fully taken effect.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, b, hi_in, lo_in);
        longint sa, sb, qt, rm;
        logic [63:0] res;
        res = {hi_in, lo_in};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: res = sa * sb;
            3'd2: res = {32'b0, a} * {32'b0, b};
            3'd3: if (b != 0) begin
                qt = sa / sb;
                rm = sa % sb;
                res = {rm[31:0], qt[31:0]};
            end
            3'd4: if (b != 0) res = {a % b, a / b};
            3'd5: res[63:32] = a;
            3'd6: res[31:0] = a;
            default: ;
        endcase
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            mon_busy  = (cyc >= busy_from) && (cyc <= busy_to);
            mon_stall = is_md(IdInst) && (mon_busy || (ExValid && ExOp >= 3'd1 && ExOp <= 3'd4));
            check("busy", 32'(Busy), 32'(mon_busy));
            check("stall", 32'(Stall), 32'(mon_stall));
            while (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_result actual_cyc=%0d required_cyc=%0d", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                check("hi", HiOut, mon_e.hi);
                check("lo", LoOut, mon_e.lo);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, input logic [31:0] id0,
                         input bit hold_id);
        int t0;
        int unsigned n;
        logic [63:0] r;
        exp_t e;
        t0 = cyc;
        n = op_cycles(op, a, b);
        ExValid = 1'b1; ExOp = op; ExA = a; ExB = b; IdInst = id0;
        r = ref_md(op, a, b, m_hi, m_lo);
        m_hi = r[63:32];
        m_lo = r[31:0];
        if (n > 0) begin
            busy_from = t0 + 1;
            busy_to   = t0 + int'(n);
        end
        e.due = t0 + int'(n) + 1;
        e.hi = m_hi;
        e.lo = m_lo;
        q.push_back(e);
        step();
        for (int unsigned k = 0; k < n; k++) begin
            // Ops presented while busy must be ignored by the design.
            ExValid = ($urandom_range(3) == 0);
            ExOp = 3'($urandom_range(7));
            ExA = $urandom;
            ExB = $urandom;
            if (!hold_id) IdInst = rand_inst();
            step();
        end
        ExValid = 1'b0;
        ExOp = 3'($urandom_range(7));
        if (!hold_id) IdInst = rand_inst();
    endtask

    task automatic reset_mid();
        exp_t e;
        int t0;
        t0 = cyc;
        ExValid = 1'b1; ExOp = 3'd1; ExA = $urandom | 32'd1; ExB = $urandom | 32'd1; IdInst = I_MFHI;
        busy_from = t0 + 1;
        busy_to   = t0 + int'(MULT_N);
        step();
        ExValid = 1'b0;
        step();
        reset = 1'b1;
        busy_to = cyc;
        step();
        step();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        e.due = cyc; e.hi = '0; e.lo = '0;
        q.push_back(e);
        step();
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; ExValid = 1'b0; ExOp = '0; ExA = '0; ExB = '0; IdInst = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        e.due = cyc; e.hi = '0; e.lo = '0;
        q.push_back(e);

        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, I_ADDU, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, I_ADDU, 1'b0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, rand_inst(), 1'b0);
        do_op(3'd4, 32'd7, 32'd0, rand_inst(), 1'b0);
        do_op(3'd5, 32'h1234_5678, 32'd0, rand_inst(), 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, rand_inst(), 1'b0);
        do_op(3'd1, 32'd3, 32'd4, I_MFLO, 1'b1);
        do_op(3'd1, 32'd5, 32'd6, I_ADDU, 1'b1);
        do_op(3'd1, 32'd0, 32'h0000_1234, I_MFHI, 1'b1);
        do_op(3'd6, 32'hCAFE_F00D, 32'd0, I_MFLO, 1'b0);
        reset_mid();

        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(7)), rand_opnd(), rand_opnd(), rand_inst(), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) begin
                IdInst = rand_inst();
                step();
            end
        end

        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual_pending=%0d required_pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
